ofdm_intlv_pingpong: RTL and testbench
======================================

// Module: ofdm_intlv_pingpong
// PURPOSE
//  Parametrised 802.11a block interleaver between the convolutional encoder and the QAM mapper.
//  - Supports all four modulation modes, selected per symbol (BPSC 1/2/4/6).
//  - Uses two ping-pong flop banks, so one symbol fills while the previous symbol drains.
//  - Takes one coded bit per beat and emits one subcarrier group of BPSC bits per beat.
//  - valid/ready handshake on both sides.
// PARAMETERS
//  N_SD      48   data subcarriers per OFDM symbol
//  MAX_BPSC  6    maximum coded bits per subcarrier; sets output bus width
//  BANK_W    N_SD*MAX_BPSC (288)  bits per bank, derived; do not override
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  bpsc       in   3         mode; legal values 1,2,4,6; sampled on first bit of a symbol
//  in_data    in   1         coded bit
//  in_val     in   1         in_data valid
//  in_rdy     out  1         write bank can accept a bit
//  out_data   out  MAX_BPSC  subcarrier group; LSB-aligned, bits above out_bpsc are 0
//  out_bpsc   out  3         mode of the symbol being drained
//  out_last   out  1         current group is group N_SD-1 of its symbol
//  out_val    out  1         out_data valid
//  out_rdy    in   1         mapper accepts the group
//  clear      in   1         synchronous flush of both banks and all counters
// BEHAVIOUR
//  Reset (reset=0, async) and clear=1 (sync) produce the same state:
//   - both banks EMPTY; wr_bank=0, rd_bank=0; k=0, m=0
//   - in_rdy=1 once reset is released; in_rdy=0 while clear=1
//   - out_val=0, out_data=0, out_bpsc=1, out_last=0
//   - bank contents are not cleared
//  Bank state, per bank: EMPTY -> FILLING (first write) -> FULL (write k=NCBPS-1)
//   -> DRAINING (first accepted group) -> EMPTY (group N_SD-1 accepted).
//  Mode latching:
//   - NCBPS = N_SD*bpsc, latched into the write bank when k=0 is written.
//   - Illegal bpsc (0,3,5,7) is latched as 1.
//   - bpsc changes during FILLING are ignored.
//  Write side:
//   - in_rdy = write bank is EMPTY or FILLING.
//   - On in_val&&in_rdy: bit k goes to permuted address j; k increments.
//   - At k=NCBPS-1: bank becomes FULL, k wraps to 0, wr_bank toggles.
//  Permutation, with r=k%16, q=k/16, s=max(bpsc/2,1):
//   - i = 3*bpsc*r + q
//   - j = s*(i/s) + ((i - r) mod s)
//   - r and q are kept as counters; no dividers. r counts 0..15; q increments when r wraps.
//  Read side:
//   - out_val = rd bank is FULL or DRAINING.
//   - out_data = bank[m*bpsc +: bpsc], zero-extended; registered-free mux from flops.
//   - On out_val&&out_rdy: m increments.
//   - At m=N_SD-1: bank becomes EMPTY, m wraps to 0, rd_bank toggles.
//   - out_data, out_bpsc and out_last are held stable while out_val&&!out_rdy.
//  Latency: first group is valid the cycle after the last bit of the symbol is written.
//  Throughput: continuous input, one bit per cycle, is sustained when the reader drains
//   N_SD groups within NCBPS cycles.
//  Both banks FULL: in_rdy=0 until the read bank drains. No data is lost or overwritten.
//  Same cycle write-complete and drain-complete: legal, because the two banks are
//   always different. Both state updates take effect.
//  clear wins over any simultaneous handshake; a partially filled symbol is discarded.
//  Reset asserted mid-operation discards all data; the block restarts from bank 0.
// TESTING
//  1 Reset:
//    - reset=0 mid-drain -> out_val=0 immediately, asynchronously.
//    - After release: in_rdy=1, out_bpsc=1.
//  2 BPSK (bpsc=1), 48 bits with only k=1 set:
//    - out_val rises 1 cycle after the 48th write.
//    - Group 3 is 1; all other groups are 0.
//    - out_last only on group 47.
//  3 16-QAM (bpsc=4), only k=1 set -> only bit j=13 set: group 3, out_data=4'b0010.
//  4 64-QAM (bpsc=6):
//    - only k=1 set -> only bit j=20 set: group 3, out_data=6'b000100.
//    - only k=17 set -> only bit j=18 set: group 3, out_data=6'b000001.
//  5 Back-pressure:
//    - out_rdy=0 while 2 symbols are written -> in_rdy=0 after bit 2*NCBPS.
//    - out_rdy=1 -> symbol 1 drains intact, then in_rdy=1.
//  6 Mode switch and clear:
//    - bpsc=2 symbol followed by bpsc=6 symbol -> out_bpsc = 2 then 6.
//    - clear at k=100 -> banks EMPTY; next symbol is correct.

Source files
------------

// File: rtl/ofdm_intlv_pingpong.sv
// ofdm_intlv_pingpong
//   802.11a block interleaver that sits between the convolutional encoder and
//   the QAM mapper. Two ping-pong flop banks let one OFDM symbol fill, one coded
//   bit per beat, while the previous symbol drains one subcarrier group of bpsc
//   bits per beat. The modulation mode (1/2/4/6 coded bits per subcarrier) is
//   chosen per symbol.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   bpsc      mode for the symbol being written; sampled on its first bit
//   in_data   coded bit
//   in_val    in_data valid
//   in_rdy    the write bank can accept a bit
//   out_data  subcarrier group, LSB-aligned, unused upper bits are 0
//   out_bpsc  mode of the symbol being drained (1 when idle)
//   out_last  current group is the final group of its symbol
//   out_val   out_data valid
//   out_rdy   mapper accepts the group
//   clear     synchronous flush of both banks and all counters

module ofdm_intlv_pingpong #(
  parameter int N_SD     = 48,
  parameter int MAX_BPSC = 6,
  parameter int BANK_W   = N_SD * MAX_BPSC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          bpsc,
  input  logic                in_data,
  input  logic                in_val,
  output logic                in_rdy,
  output logic [MAX_BPSC-1:0] out_data,
  output logic [2:0]          out_bpsc,
  output logic                out_last,
  output logic                out_val,
  input  logic                out_rdy,
  input  logic                clear
);

  localparam int KW = $clog2(BANK_W);
  localparam int MW = $clog2(N_SD);
  localparam logic [MW-1:0] M_LAST = MW'(N_SD - 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL,
    ST_DRAINING
  } bank_st_t;

  // Any mode outside {1,2,4,6} falls back to BPSK.
  function automatic logic [2:0] legal_bpsc(input logic [2:0] b);
    case (b)
      3'd1, 3'd2, 3'd4, 3'd6: legal_bpsc = b;
      default:                legal_bpsc = 3'd1;
    endcase
  endfunction

  // Index of the final bit of a symbol, NCBPS-1.
  function automatic logic [KW-1:0] last_k(input logic [2:0] b);
    case (b)
      3'd2:    last_k = KW'(2 * N_SD - 1);
      3'd4:    last_k = KW'(4 * N_SD - 1);
      3'd6:    last_k = KW'(6 * N_SD - 1);
      default: last_k = KW'(N_SD - 1);
    endcase
  endfunction

  // Two-step 802.11a permutation from the r = k%16, q = k/16 counters.
  //   i = 3*bpsc*r + q, built from shifts.
  //   Second step with s = max(bpsc/2,1):
  //     s=1 : j = i
  //     s=2 : i mod 2 = q mod 2 and (i-r) mod 2 = (q^r) mod 2, so only bit 0 changes.
  //     s=3 : 18r is a multiple of 3, so i mod 3 = q mod 3 and
  //           (i-r) mod 3 = (q-r) mod 3; both come from the mod-3 shadow counters.
  function automatic logic [KW-1:0] perm_addr(
    input logic [2:0] b,
    input logic [3:0] r,
    input logic [4:0] q,
    input logic [1:0] qm3,
    input logic [1:0] rm3
  );
    logic [KW-1:0] rr;
    logic [KW-1:0] i;
    logic [1:0]    d;
    rr = KW'(r);
    case (b)
      3'd2:    i = (rr << 2) + (rr << 1) + KW'(q);
      3'd4:    i = (rr << 3) + (rr << 2) + KW'(q);
      3'd6:    i = (rr << 4) + (rr << 1) + KW'(q);
      default: i = (rr << 1) + rr + KW'(q);
    endcase
    d = (qm3 >= rm3) ? (qm3 - rm3) : (qm3 + 2'd3 - rm3);
    case (b)
      3'd4:    perm_addr = {i[KW-1:1], q[0] ^ r[0]};
      3'd6:    perm_addr = i - KW'(qm3) + KW'(d);
      default: perm_addr = i;
    endcase
  endfunction

  // First bit of group m inside a bank, m*bpsc.
  function automatic logic [KW-1:0] grp_base(input logic [2:0] b, input logic [MW-1:0] m);
    logic [KW-1:0] mm;
    mm = KW'(m);
    case (b)
      3'd2:    grp_base = mm << 1;
      3'd4:    grp_base = mm << 2;
      3'd6:    grp_base = (mm << 2) + (mm << 1);
      default: grp_base = mm;
    endcase
  endfunction

  logic [BANK_W-1:0] bank [2];
  bank_st_t          st [2];
  logic [2:0]        bank_bpsc [2];
  logic              wr_bank;
  logic              rd_bank;
  logic [KW-1:0]     k;
  logic [3:0]        r;
  logic [4:0]        q;
  logic [1:0]        qm3;
  logic [1:0]        rm3;
  logic [MW-1:0]     m;

  logic [2:0]        wr_bpsc;
  logic [KW-1:0]     wr_addr;
  logic              wr_fire;
  logic              wr_end;
  logic [2:0]        rd_bpsc;
  logic [KW-1:0]     rd_base;
  logic              rd_fire;

  // The mode is taken from the port on the first bit and from the bank afterwards,
  // so mid-symbol changes on bpsc have no effect.
  assign wr_bpsc = (k == '0) ? legal_bpsc(bpsc) : bank_bpsc[wr_bank];
  assign wr_addr = perm_addr(wr_bpsc, r, q, qm3, rm3);
  assign in_rdy  = !clear && ((st[wr_bank] == ST_EMPTY) || (st[wr_bank] == ST_FILLING));
  assign wr_fire = in_val && in_rdy;
  assign wr_end  = (k == last_k(wr_bpsc));

  assign out_val  = (st[rd_bank] == ST_FULL) || (st[rd_bank] == ST_DRAINING);
  assign rd_bpsc  = bank_bpsc[rd_bank];
  assign rd_base  = grp_base(rd_bpsc, m);
  assign rd_fire  = out_val && out_rdy && !clear;
  assign out_bpsc = out_val ? rd_bpsc : 3'd1;
  assign out_last = out_val && (m == M_LAST);

  // Output group is a plain mux from the bank flops; it only moves when m,
  // rd_bank or the bank state move, all of which need an accepted group.
  always_comb begin
    out_data = '0;
    for (int b = 0; b < MAX_BPSC; b++) begin
      if (out_val && (3'(b) < rd_bpsc)) begin
        out_data[b] = bank[rd_bank][rd_base + KW'(b)];
      end
    end
  end

  // Bank contents carry data only and are never reset or flushed.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank[wr_bank][wr_addr] <= in_data;
    end
  end

  // Bank state machines, bank pointers and write/read counters. The write side
  // only touches a bank that is EMPTY/FILLING and the read side only one that is
  // FULL/DRAINING, so both updates can land in the same cycle on different banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        st[b]        <= ST_EMPTY;
        bank_bpsc[b] <= 3'd1;
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      k       <= '0;
      r       <= '0;
      q       <= '0;
      qm3     <= '0;
      rm3     <= '0;
      m       <= '0;
    end else if (clear) begin
      for (int b = 0; b < 2; b++) begin
        st[b]        <= ST_EMPTY;
        bank_bpsc[b] <= 3'd1;
      end
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      k       <= '0;
      r       <= '0;
      q       <= '0;
      qm3     <= '0;
      rm3     <= '0;
      m       <= '0;
    end else begin
      if (wr_fire) begin
        if (k == '0) begin
          bank_bpsc[wr_bank] <= wr_bpsc;
          st[wr_bank]        <= ST_FILLING;
        end
        if (wr_end) begin
          st[wr_bank] <= ST_FULL;
          wr_bank     <= ~wr_bank;
          k           <= '0;
          r           <= '0;
          q           <= '0;
          qm3         <= '0;
          rm3         <= '0;
        end else begin
          k <= k + KW'(1);
          if (r == 4'd15) begin
            r   <= '0;
            rm3 <= '0;
            q   <= q + 5'd1;
            qm3 <= (qm3 == 2'd2) ? 2'd0 : qm3 + 2'd1;
          end else begin
            r   <= r + 4'd1;
            rm3 <= (rm3 == 2'd2) ? 2'd0 : rm3 + 2'd1;
          end
        end
      end
      if (rd_fire) begin
        if (m == M_LAST) begin
          st[rd_bank] <= ST_EMPTY;
          rd_bank     <= ~rd_bank;
          m           <= '0;
        end else begin
          st[rd_bank] <= ST_DRAINING;
          m           <= m + MW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ofdm_intlv_pingpong.sv
// Testbench for ofdm_intlv_pingpong: randomized and directed symbols against a
// behavioural interleaver model built from the permutation formulas.
module tb_ofdm_intlv_pingpong;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] bpsc = 3'd1;
  logic       in_data = 1'b0;
  logic       in_val = 1'b0;
  logic       in_rdy;
  logic [5:0] out_data;
  logic [2:0] out_bpsc;
  logic       out_last;
  logic       out_val;
  logic       out_rdy = 1'b1;
  logic       clear = 1'b0;

  ofdm_intlv_pingpong #(.N_SD(48), .MAX_BPSC(6)) dut (
    .clk(clk), .reset(reset), .bpsc(bpsc), .in_data(in_data), .in_val(in_val),
    .in_rdy(in_rdy), .out_data(out_data), .out_bpsc(out_bpsc), .out_last(out_last),
    .out_val(out_val), .out_rdy(out_rdy), .clear(clear)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [5:0] data;
    logic [2:0] b;
    logic       last;
  } grp_t;

  grp_t       expq[$];
  int         mk = 0;
  logic [2:0] mb = 3'd1;
  logic [287:0] mbits;
  int         rd_grp = 0;
  logic [5:0] cap [48];
  int         last_idx = -1;
  int         bps_log[$];
  int         pend;
  int         rdy_mode = 0;

  function automatic logic [2:0] legal(input logic [2:0] b);
    if (b == 3'd1 || b == 3'd2 || b == 3'd4 || b == 3'd6) return b;
    return 3'd1;
  endfunction

  function automatic int j_of(input int k, input int b);
    int s, r, q, i;
    s = (b / 2 > 1) ? b / 2 : 1;
    r = k % 16;
    q = k / 16;
    i = 3 * b * r + q;
    return s * (i / s) + ((i - r) % s);
  endfunction

  task automatic build_symbol();
    logic [287:0] perm;
    int b;
    grp_t e;
    perm = '0;
    b = int'(mb);
    for (int kk = 0; kk < 48 * b; kk++) perm[j_of(kk, b)] = mbits[kk];
    for (int g = 0; g < 48; g++) begin
      e.data = '0;
      for (int t = 0; t < b; t++) e.data[t] = perm[g * b + t];
      e.b = mb;
      e.last = (g == 47);
      expq.push_back(e);
    end
  endtask

  // One compare process: checks outputs against the model, then applies the
  // handshakes that will take effect at the coming rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      expq.delete();
      mk = 0;
      rd_grp = 0;
    end else begin
      pend = (expq.size() + 47) / 48;
      chk("in_rdy", in_rdy, (pend < 2) && !clear);
      chk("out_val", out_val, expq.size() > 0);
      if (expq.size() > 0) begin
        chk("out_data", out_data, expq[0].data);
        chk("out_bpsc", out_bpsc, expq[0].b);
        chk("out_last", out_last, expq[0].last);
      end else begin
        chk("idle_data", out_data, 0);
      end
      if (clear) begin
        expq.delete();
        mk = 0;
        rd_grp = 0;
      end else begin
        if (out_val && out_rdy && expq.size() > 0) begin
          if (rd_grp == 0) bps_log.push_back(int'(out_bpsc));
          cap[rd_grp] = out_data;
          if (out_last) last_idx = rd_grp;
          rd_grp = (rd_grp + 1) % 48;
          void'(expq.pop_front());
        end
        if (in_val && in_rdy) begin
          if (mk == 0) mb = legal(bpsc);
          mbits[mk] = in_data;
          mk++;
          if (mk == 48 * int'(mb)) begin
            build_symbol();
            mk = 0;
          end
        end
      end
    end
  end

  // Reader: 0 always ready, 1 random, 2 stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [2:0] b, input logic [287:0] d, input int nbits,
                      input int gap_pct, output int cyc);
    int k;
    logic hs;
    k = 0;
    cyc = 0;
    while (k < nbits) begin
      in_val  = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      in_data = d[k];
      bpsc    = (k == 0) ? b : 3'($urandom);
      @(negedge clk);
      hs = in_val && in_rdy;
      @(posedge clk);
      #1;
      if (hs) k++;
      cyc++;
      if (cyc > 5000) begin
        timeout("send");
        break;
      end
    end
    in_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq.size() > 0 || out_val) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) timeout("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [287:0] rand_bits();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [287:0] pat;
  logic [2:0]   rb;
  int           cyc;

  initial begin
    // Model pinned against hand-worked permutation values.
    chk("j_bpsk_k1", j_of(1, 1), 3);
    chk("j_16qam_k1", j_of(1, 4), 13);
    chk("j_64qam_k1", j_of(1, 6), 20);
    chk("j_64qam_k17", j_of(17, 6), 18);

    // Reset state
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_bpsc", out_bpsc, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;

    // BPSK, only k=1 set; first group one cycle after the 48th write
    rdy_mode = 0;
    pat = '0;
    pat[1] = 1'b1;
    send(3'd1, pat, 48, 0, cyc);
    chk("bpsk_latency", out_val, 1);
    wait_drain();
    chk("bpsk_grp3", cap[3], 1);
    chk("bpsk_grp2", cap[2], 0);
    chk("bpsk_last_idx", last_idx, 47);

    // 16-QAM, only k=1 set
    send(3'd4, pat, 192, 20, cyc);
    wait_drain();
    chk("qam16_grp3", cap[3], 6'b000010);

    // 64-QAM, only k=1 set, then only k=17 set
    send(3'd6, pat, 288, 0, cyc);
    wait_drain();
    chk("qam64_k1_grp3", cap[3], 6'b000100);
    pat = '0;
    pat[17] = 1'b1;
    send(3'd6, pat, 288, 0, cyc);
    wait_drain();
    chk("qam64_k17_grp3", cap[3], 6'b000001);

    // Continuous BPSK input with an always-ready reader never stalls
    send(3'd1, rand_bits(), 48, 0, cyc);
    chk("stream_cyc_a", cyc, 48);
    send(3'd1, rand_bits(), 48, 0, cyc);
    chk("stream_cyc_b", cyc, 48);
    wait_drain();

    // Back-pressure: two QPSK symbols with the reader stalled
    rdy_mode = 2;
    send(3'd2, rand_bits(), 96, 0, cyc);
    send(3'd2, rand_bits(), 96, 0, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_in_rdy_low", in_rdy, 0);
    chk("bp_out_val", out_val, 1);
    rdy_mode = 0;
    wait_drain();
    chk("bp_in_rdy_high", in_rdy, 1);

    // Mode switch QPSK -> 64-QAM
    rdy_mode = 1;
    bps_log.delete();
    send(3'd2, rand_bits(), 96, 10, cyc);
    send(3'd6, rand_bits(), 288, 10, cyc);
    wait_drain();
    chk("mode_log_n", bps_log.size(), 2);
    if (bps_log.size() == 2) begin
      chk("mode_first", bps_log[0], 2);
      chk("mode_second", bps_log[1], 6);
    end

    // clear with one full symbol pending and another at k=100
    rdy_mode = 2;
    send(3'd1, rand_bits(), 48, 0, cyc);
    send(3'd4, rand_bits(), 100, 0, cyc);
    clear = 1'b1;
    #1;
    chk("clr_in_rdy", in_rdy, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("clr_out_val", out_val, 0);
    chk("clr_in_rdy_after", in_rdy, 1);
    chk("clr_out_bpsc", out_bpsc, 1);
    rdy_mode = 0;
    send(3'd4, rand_bits(), 192, 0, cyc);
    wait_drain();

    // Randomized symbols, including illegal modes and gaps
    rdy_mode = 1;
    for (int s = 0; s < 8; s++) begin
      rb = 3'($urandom);
      send(rb, rand_bits(), 48 * int'(legal(rb)), 30, cyc);
    end
    wait_drain();

    // Reset asserted mid-drain
    send(3'd6, rand_bits(), 288, 0, cyc);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out_val", out_val, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rel_in_rdy", in_rdy, 1);
    chk("rel_out_bpsc", out_bpsc, 1);
    rdy_mode = 0;
    send(3'd2, rand_bits(), 96, 0, cyc);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
